// File: rtl/turing_job_scheduler_pkg.sv
// Shared definitions for the turing_job_scheduler slice: FSM encoding,
// default tape width and a constant-friendly ceil(log2) helper.
package turing_job_scheduler_pkg;

  localparam int TAPE_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_RESP
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/turing_job_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first request after ptr, wrapping modulo NUM_REQ.
// The pointer register itself is owned by the scheduler.
module rr_arbiter
  import turing_job_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  int   cand;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/turing_job_scheduler.sv
// Time-shares one turing_machine engine between NUM_REQ requesters: round-robin
// grant, load, start, run until halt or timeout, then hand the tape back.
module turing_job_scheduler
  import turing_job_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAPE_W  = TAPE_W_DEFAULT,
  parameter int TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*TAPE_W-1:0]   req_tape,
  output logic [NUM_REQ-1:0]          req_grant,
  output logic                        rsp_valid,
  output logic [clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [TAPE_W-1:0]           rsp_tape,
  output logic                        rsp_timeout,
  input  logic                        rsp_ready,
  output logic                        busy,
  output logic                        tm_reset,
  output logic                        tm_ready,
  output logic [TAPE_W-1:0]           tm_tape,
  input  logic [TAPE_W-1:0]           tm_tape_q,
  input  logic                        tm_done,
  input  logic                        tm_halted
);

  localparam int IDX_W = clog2(NUM_REQ);
  localparam int TMO_W = clog2(TIMEOUT) + 1;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     cur_id_q, cur_id_d;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [NUM_REQ-1:0]   req_grant_q, req_grant_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [IDX_W-1:0]     rsp_id_q, rsp_id_d;
  logic [TAPE_W-1:0]    rsp_tape_q, rsp_tape_d;
  logic                 rsp_timeout_q, rsp_timeout_d;
  logic                 busy_q, busy_d;
  logic                 tm_reset_q, tm_reset_d;
  logic                 tm_ready_q, tm_ready_d;
  logic [TAPE_W-1:0]    load_tape_q, load_tape_d;
  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic [TAPE_W-1:0]    sel_tape;
  logic                 job_end;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  always_comb begin
    sel_tape = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) sel_tape = req_tape[i*TAPE_W +: TAPE_W];
    end
  end

  // Every output is computed for the state being entered, so it is registered
  // and already valid on the first cycle of that state.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cur_id_d      = cur_id_q;
    tmo_cnt_d     = tmo_cnt_q;
    req_grant_d   = '0;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_tape_d    = rsp_tape_q;
    rsp_timeout_d = rsp_timeout_q;
    tm_reset_d    = tm_reset_q;
    tm_ready_d    = 1'b0;
    load_tape_d   = load_tape_q;
    job_end       = tm_done || tm_halted;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          req_grant_d = arb_grant;
          load_tape_d = sel_tape;
          cur_id_d    = arb_idx;
          ptr_d       = arb_idx;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        tm_reset_d = 1'b0;
        tm_ready_d = 1'b1;
        state_d    = ST_START;
      end
      ST_START: begin
        tmo_cnt_d = '0;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        if (tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + 1'b1;
        // A job that halts on the last allowed cycle still counts as a clean finish.
        if (job_end || (tmo_cnt_q == TMO_W'(TIMEOUT - 1))) begin
          rsp_valid_d   = 1'b1;
          rsp_id_d      = cur_id_q;
          rsp_tape_d    = tm_tape_q;
          rsp_timeout_d = !job_end;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          tm_reset_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ptr_q         <= IDX_W'(NUM_REQ - 1);
      cur_id_q      <= '0;
      tmo_cnt_q     <= '0;
      req_grant_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_tape_q    <= '0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      tm_reset_q    <= 1'b1;
      tm_ready_q    <= 1'b0;
      load_tape_q   <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cur_id_q      <= cur_id_d;
      tmo_cnt_q     <= tmo_cnt_d;
      req_grant_q   <= req_grant_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_tape_q    <= rsp_tape_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
      tm_reset_q    <= tm_reset_d;
      tm_ready_q    <= tm_ready_d;
      load_tape_q   <= load_tape_d;
    end
  end

  assign req_grant   = req_grant_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_tape    = rsp_tape_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = busy_q;
  assign tm_reset    = tm_reset_q;
  assign tm_ready    = tm_ready_q;
  assign tm_tape     = load_tape_q;

endmodule

// File: tb/tb_turing_job_scheduler.sv
// Bench for turing_job_scheduler: a small behavioural tape engine plus a job-level
// reference model predicting grant order, result tape, timeout flag and latency.
module tb_turing_job_scheduler;

  localparam int NUM_REQ = 4;
  localparam int TAPE_W  = 8;
  localparam int TIMEOUT = 16;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*TAPE_W-1:0] req_tape = '0;
  logic [NUM_REQ-1:0]        req_grant;
  logic                      rsp_valid;
  logic [1:0]                rsp_id;
  logic [TAPE_W-1:0]         rsp_tape;
  logic                      rsp_timeout;
  logic                      rsp_ready = 1'b0;
  logic                      busy;
  logic                      tm_reset;
  logic                      tm_ready;
  logic [TAPE_W-1:0]         tm_tape;
  logic [TAPE_W-1:0]         tm_tape_q;
  logic                      tm_done;
  logic                      tm_halted;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  turing_job_scheduler #(.NUM_REQ(NUM_REQ), .TAPE_W(TAPE_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_tape(req_tape),
    .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_tape(rsp_tape),
    .rsp_timeout(rsp_timeout), .rsp_ready(rsp_ready), .busy(busy), .tm_reset(tm_reset),
    .tm_ready(tm_ready), .tm_tape(tm_tape), .tm_tape_q(tm_tape_q), .tm_done(tm_done),
    .tm_halted(tm_halted)
  );

  // Toy engine: head starts at the MSB and walks down; the first 0 it meets is
  // written to 1 and the machine halts. An all-ones tape never halts.
  logic [TAPE_W-1:0] eng_tape;
  logic [2:0]        eng_head;
  logic              eng_run, eng_done;

  always @(posedge clk) begin
    if (tm_reset) begin
      eng_tape <= tm_tape; eng_head <= 3'd7; eng_run <= 1'b0; eng_done <= 1'b0;
    end else if (tm_ready) begin
      eng_run <= 1'b1;
    end else if (eng_run && !eng_done) begin
      if (!eng_tape[eng_head]) begin
        eng_tape[eng_head] <= 1'b1; eng_done <= 1'b1;
      end else begin
        eng_head <= eng_head - 3'd1;
      end
    end
  end

  assign tm_tape_q = eng_tape;
  assign tm_done   = eng_done;
  assign tm_halted = eng_done;

  // Job-level prediction. The engine needs (TAPE_W - z) steps to reach the highest
  // zero bit z; done becomes visible one RUN cycle after the last step. Latency is
  // counted from the cycle the grant is visible to the cycle rsp_valid is visible.
  function automatic void model_job(input logic [TAPE_W-1:0] tape, output logic [TAPE_W-1:0] res,
                                    output logic tmo, output int lat);
    int z = -1;
    int steps;
    for (int b = TAPE_W - 1; b >= 0; b--) if (!tape[b] && z < 0) z = b;
    steps = TAPE_W - z;
    if (z < 0 || steps + 1 > TIMEOUT) begin
      res = tape; tmo = 1'b1; lat = 2 + TIMEOUT;
    end else begin
      res = tape | (TAPE_W'(1) << z); tmo = 1'b0; lat = 3 + steps;
    end
  endfunction

  // Drives one job and records what the DUT did; comparisons live in the callers.
  task automatic run_job(input int id, input logic [TAPE_W-1:0] tape, input int hold,
                         output logic [NUM_REQ-1:0] gnt, output int lat, output logic [1:0] rid,
                         output logic [TAPE_W-1:0] rtape, output logic rtmo, output logic stable,
                         output logic after_valid, output logic after_busy);
    req_tape[id*TAPE_W +: TAPE_W] = tape;
    req_valid[id] = 1'b1;
    rsp_ready = 1'b0;
    gnt = '0;
    for (int i = 0; i < 40 && gnt == '0; i++) begin
      @(posedge clk); #1; gnt = req_grant;
    end
    req_valid[id] = 1'b0;
    lat = -1;
    for (int i = 1; i < 60; i++) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) begin lat = i; break; end
    end
    rid = rsp_id; rtape = rsp_tape; rtmo = rsp_timeout; stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_id !== rid || rsp_tape !== rtape || rsp_timeout !== rtmo ||
          busy !== 1'b1 || req_grant !== '0) stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    after_valid = rsp_valid; after_busy = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; req_tape = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_grant !== 4'b0) begin errors++; $display("[TB] FAIL reset_grant: got %b want 0000", req_grant); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    checks++; if (rsp_tape !== 8'h00) begin errors++; $display("[TB] FAIL reset_rsp_tape: got %h want 00", rsp_tape); end
    checks++; if (rsp_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_timeout: got %b want 0", rsp_timeout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (tm_reset !== 1'b1) begin errors++; $display("[TB] FAIL reset_tm_reset: got %b want 1", tm_reset); end
    checks++; if (tm_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_tm_ready: got %b want 0", tm_ready); end
    checks++; if (tm_tape !== 8'h00) begin errors++; $display("[TB] FAIL reset_tm_tape: got %h want 00", tm_tape); end
    reset = 1'b0;
  endtask

  // Directed job with expectations from the model and the requester index.
  task automatic test_job(input string name, input int id, input logic [TAPE_W-1:0] tape);
    logic [NUM_REQ-1:0] gnt; int lat; logic [1:0] rid; logic [TAPE_W-1:0] rtape, etape;
    logic rtmo, etmo, stable, av, ab; int elat;
    model_job(tape, etape, etmo, elat);
    run_job(id, tape, 0, gnt, lat, rid, rtape, rtmo, stable, av, ab);
    checks++; if (gnt !== 4'(1 << id)) begin errors++; $display("[TB] FAIL %s_grant: got %b want %b", name, gnt, 4'(1 << id)); end
    checks++; if (lat != elat) begin errors++; $display("[TB] FAIL %s_latency: got %0d want %0d", name, lat, elat); end
    checks++; if (rid !== 2'(id)) begin errors++; $display("[TB] FAIL %s_rsp_id: got %0d want %0d", name, rid, id); end
    checks++; if (rtape !== etape) begin errors++; $display("[TB] FAIL %s_rsp_tape: got %h want %h", name, rtape, etape); end
    checks++; if (rtmo !== etmo) begin errors++; $display("[TB] FAIL %s_rsp_timeout: got %b want %b", name, rtmo, etmo); end
    checks++; if (av !== 1'b0 || ab !== 1'b0) begin errors++; $display("[TB] FAIL %s_back_to_idle: got valid=%b busy=%b want 0 0", name, av, ab); end
  endtask

  // Requester 0 stays pending while requester 3's result is held back.
  task automatic test_backpressure();
    logic [NUM_REQ-1:0] gnt; int lat; logic [1:0] rid; logic [TAPE_W-1:0] rtape, etape, t;
    logic rtmo, etmo, stable, av, ab; int elat;
    t = TAPE_W'($urandom) & 8'hEF;
    model_job(t, etape, etmo, elat);
    req_tape[0 +: TAPE_W] = 8'hFF;
    req_valid[0] = 1'b1;
    run_job(3, t, 5, gnt, lat, rid, rtape, rtmo, stable, av, ab);
    checks++; if (gnt !== 4'b1000) begin errors++; $display("[TB] FAIL bp_grant: got %b want 1000", gnt); end
    checks++; if (rtape !== etape || rid !== 2'd3) begin errors++; $display("[TB] FAIL bp_rsp: got id=%0d tape=%h want id=3 tape=%h", rid, rtape, etape); end
    checks++; if (stable !== 1'b1) begin errors++; $display("[TB] FAIL bp_stable: got %b want 1", stable); end
    checks++; if (av !== 1'b0) begin errors++; $display("[TB] FAIL bp_release: got rsp_valid=%b want 0", av); end
  endtask

  task automatic test_reset_mid_run();
    logic seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin @(posedge clk); #1; seen = req_grant[0]; end
    req_valid[0] = 1'b0;
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL midrun_pending_grant: got %b want 1", seen); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1 || tm_reset !== 1'b0) begin errors++; $display("[TB] FAIL midrun_running: got busy=%b tm_reset=%b want 1 0", busy, tm_reset); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || tm_reset !== 1'b1 || req_grant !== '0) begin
      errors++; $display("[TB] FAIL midrun_reset: got valid=%b busy=%b tm_reset=%b grant=%b want 0 0 1 0000", rsp_valid, busy, tm_reset, req_grant);
    end
    reset = 1'b0;
    req_valid = 4'b0011;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin @(posedge clk); #1; seen = |req_grant; end
    checks++; if (req_grant !== 4'b0001) begin errors++; $display("[TB] FAIL midrun_ptr_restart: got %b want 0001", req_grant); end
    req_valid = '0;
  endtask

  // Back-to-back jobs with rsp_ready high. all_on keeps every requester pending,
  // otherwise new requests arrive at random; the model picks the first pending
  // requester after the last winner.
  task automatic test_back_to_back(input string name, input int njobs, input bit all_on);
    bit [NUM_REQ-1:0] pend = '0;
    logic [TAPE_W-1:0] tp [NUM_REQ];
    logic [TAPE_W-1:0] etape;
    logic etmo, seen;
    int mptr, exp, elat, lat, c;
    reset = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; rsp_ready = 1'b1; mptr = NUM_REQ - 1;
    for (int j = 0; j < njobs; j++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend[i] && (all_on || $urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1; tp[i] = TAPE_W'($urandom);
          req_tape[i*TAPE_W +: TAPE_W] = tp[i]; req_valid[i] = 1'b1;
        end
      end
      if (pend == '0) begin
        c = $urandom_range(0, NUM_REQ - 1);
        pend[c] = 1'b1; tp[c] = TAPE_W'($urandom);
        req_tape[c*TAPE_W +: TAPE_W] = tp[c]; req_valid[c] = 1'b1;
      end
      exp = -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
        c = (mptr + k) % NUM_REQ;
        if (exp < 0 && pend[c]) exp = c;
      end
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin @(posedge clk); #1; seen = |req_grant; end
      checks++; if (req_grant !== 4'(1 << exp)) begin errors++; $display("[TB] FAIL %s_grant job %0d: got %b want %b", name, j, req_grant, 4'(1 << exp)); end
      mptr = exp; pend[exp] = 1'b0; req_valid[exp] = 1'b0;
      model_job(tp[exp], etape, etmo, elat);
      lat = -1;
      for (int i = 1; i < 60; i++) begin
        @(posedge clk); #1;
        if (rsp_valid === 1'b1) begin lat = i; break; end
      end
      checks++; if (rsp_id !== 2'(exp) || rsp_tape !== etape || rsp_timeout !== etmo || lat != elat) begin
        errors++; $display("[TB] FAIL %s_rsp job %0d: got id=%0d tape=%h tmo=%b lat=%0d want id=%0d tape=%h tmo=%b lat=%0d",
                           name, j, rsp_id, rsp_tape, rsp_timeout, lat, exp, etape, etmo, elat);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0; req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_job("single", 0, 8'b0111_1111);
    test_job("long", 2, 8'b1111_1110);
    test_job("timeout", 1, 8'hFF);
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back("round_robin", 5, 1'b1);
    test_back_to_back("random", 16, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
